pair_exchange_engine: RTL and testbench
=======================================

Name: pair_exchange_engine

Overview:
- Accepts an operand pair (A, B), then exchanges the two registers once per clock for a programmed number of cycles.
- Each exchange is simultaneous: both registers update on the same edge from the old values, so neither operand is lost.
- Presents the resulting pair downstream over a valid/ready handshake.
- Sits directly downstream of the register-exchange demonstration stage. It is the synthesizable, handshaked consumer and generalisation of that two-register swap.

Parameters:
- WIDTH, 8, bit width of each operand register.
- MAX_SWAPS, 15, maximum exchange count accepted per transaction.
- CW, $clog2(MAX_SWAPS+1) (derived localparam), exchange-count width.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  block can accept a pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_swaps  input  CW  requested exchange count.
- out_valid  output  1  result pair valid.
- out_ready  input  1  downstream accepts the result.
- out_a  output  WIDTH  result register A.
- out_b  output  WIDTH  result register B.
- busy  output  1  high in SWAP or DONE.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - state=IDLE, a_reg=0, b_reg=0, cnt=0.
  - in_ready=1, out_valid=0, busy=0, out_a=0, out_b=0.
- Reset asserted mid-SWAP or mid-DONE discards the transaction. No partial output is emitted.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a_reg=in_a, b_reg=in_b, cnt=min(in_swaps, MAX_SWAPS).
  - Next state is DONE if the clamped count is 0, otherwise SWAP.
- State SWAP:
  - Every cycle: a_reg<=b_reg and b_reg<=a_reg on the same edge; cnt<=cnt-1.
  - When cnt==1, perform the final exchange and go to DONE.
  - in_ready=0. Upstream inputs are ignored.
- State DONE:
  - out_valid=1; out_a/out_b are driven directly from a_reg/b_reg, with no extra output register.
  - Data must stay stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; in_ready rises the following cycle. There is no same-cycle accept-while-emitting.
- Latency: a pair accepted at edge k yields out_valid after edge k+N, where N is the clamped count. N=0 gives out_valid after edge k.
- Result rule: for even N, out_a=in_a and out_b=in_b. For odd N, out_a=in_b and out_b=in_a.
- Clamp: in_swaps values above MAX_SWAPS are treated as MAX_SWAPS. This only applies when MAX_SWAPS+1 is not a power of 2.
- in_valid held high in DONE is not accepted. The pair is taken only once IDLE is re-entered.
- Throughput: at most one transaction per N+2 cycles.

Optional Feature:
- Macro: PAIR_EXCHANGE_STATS_EN.
- When defined, add output port swap_total (16 bits):
  - Counts every exchange performed in SWAP.
  - Saturates at 16'hFFFF; does not wrap.
  - Reset to 0 by reset_n.
  - Not cleared between transactions.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: reset_n=0 at any time -> in_ready=1, out_valid=0, busy=0, out_a=out_b=0 immediately, before any clk edge.
- Odd count: in_a=8'hA5, in_b=8'h3C, in_swaps=1, out_ready=1 -> out_valid asserted 1 cycle after accept with out_a=3C, out_b=A5; in_ready back to 1 two cycles after accept.
- Even count: in_a=8'h12, in_b=8'h34, in_swaps=4 -> out_valid after 4 cycles with out_a=12, out_b=34; busy high for 5 cycles (4 SWAP + 1 DONE).
- Zero count plus backpressure: in_swaps=0, in_a=01, in_b=02, out_ready=0 for 3 cycles -> out_valid held with 01/02 stable and in_ready=0 throughout; output accepted on the 4th cycle.
- Mid-operation reset: in_swaps=15, reset_n pulsed low at cycle 7 of SWAP -> all outputs return to reset values; a following pair (55/AA, swaps=3) produces AA/55.
- Stats (PAIR_EXCHANGE_STATS_EN defined): transactions with counts 3, 0, 5 -> swap_total=8; force the counter to FFFE, then run count=3 -> swap_total=FFFF.

Source files
------------

// File: rtl/pair_exchange_engine.sv
// Handshaked two-register exchange engine: captures (A, B), swaps them N times, then presents the pair.
// Optional build macro PAIR_EXCHANGE_STATS_EN adds a saturating 16-bit swap_total exchange counter.
module pair_exchange_engine #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_SWAPS = 15,
  localparam int CW        = $clog2(MAX_SWAPS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [CW-1:0]    in_swaps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy
`ifdef PAIR_EXCHANGE_STATS_EN
  ,
  output logic [15:0]      swap_total
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    swaps_clamped;
  logic             accept;

  // The clamp only exists when the count field can encode values above MAX_SWAPS.
  generate
    if ((1 << CW) != MAX_SWAPS + 1) begin : g_clamp
      assign swaps_clamped = (in_swaps > CW'(MAX_SWAPS)) ? CW'(MAX_SWAPS) : in_swaps;
    end else begin : g_no_clamp
      assign swaps_clamped = in_swaps;
    end
  endgenerate

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = (swaps_clamped == '0) ? DONE : SWAP;
      SWAP: if (cnt == CW'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_a     = a_reg;
    out_b     = b_reg;
  end

  // NOTE: non-blocking assignments make both registers sample the old values, so the swap loses nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      cnt   <= swaps_clamped;
    end else if (state == SWAP) begin
      a_reg <= b_reg;
      b_reg <= a_reg;
      cnt   <= cnt - CW'(1);
    end
  end

`ifdef PAIR_EXCHANGE_STATS_EN
  logic [15:0] swap_total_q;

  // Lifetime exchange count; saturates rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       swap_total_q <= '0;
    else if ((state == SWAP) && (swap_total_q != 16'hFFFF)) swap_total_q <= swap_total_q + 16'd1;
  end

  assign swap_total = swap_total_q;
`endif

endmodule

// File: tb/tb_pair_exchange_engine.sv
// Directed self-checking bench for pair_exchange_engine with hand-computed expected values.
// Build with PAIR_EXCHANGE_STATS_EN defined to also exercise the swap_total counter.
module tb_pair_exchange_engine;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [CW-1:0]    in_swaps = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             busy;
`ifdef PAIR_EXCHANGE_STATS_EN
  logic [15:0]      swap_total;
`endif

  int checks = 0;
  int errors = 0;

  pair_exchange_engine #(.WIDTH(WIDTH), .MAX_SWAPS(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_swaps  (in_swaps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .busy      (busy)
`ifdef PAIR_EXCHANGE_STATS_EN
    ,
    .swap_total(swap_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_out_a"},     32'(out_a),     32'd0);
    check({tag, "_out_b"},     32'(out_b),     32'd0);
  endtask

  // Assumes the DUT is idle; returns the presented pair and cycles from accept to out_valid (-1 on timeout).
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] n,
                         output logic [7:0] ga, output logic [7:0] gb, output int lat);
    in_a = a; in_b = b; in_swaps = n; in_valid = 1'b1; out_ready = 1'b1;
    ga = '0; gb = '0; lat = -1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        ga = out_a; gb = out_b; lat = i;
        break;
      end
      tick;
    end
    tick;
  endtask

  logic [7:0] ga, gb;
  int         lat;
  int         busy_cycles;
  int         valid_at;

  initial begin
    // Reset takes effect with no clock edge.
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    tick; tick;
    reset_n = 1'b1;
    tick;

    // Odd count: N=1 swaps the pair.
    check("odd_in_ready_pre", 32'(in_ready), 32'd1);
    in_a = 8'hA5; in_b = 8'h3C; in_swaps = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    check("odd_busy_k",      32'(busy),      32'd1);
    check("odd_valid_k",     32'(out_valid), 32'd0);
    check("odd_in_ready_k",  32'(in_ready),  32'd0);
    tick;
    check("odd_valid_k1",    32'(out_valid), 32'd1);
    check("odd_out_a",       32'(out_a),     32'h3C);
    check("odd_out_b",       32'(out_b),     32'hA5);
    tick;
    check("odd_in_ready_k2", 32'(in_ready),  32'd1);
    check("odd_valid_k2",    32'(out_valid), 32'd0);

    // Even count: N=4 returns the pair unchanged; busy spans 4 SWAP + 1 DONE cycles.
    in_a = 8'h12; in_b = 8'h34; in_swaps = 4'd4; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    busy_cycles = 0; valid_at = -1;
    for (int i = 0; i < 40 && busy; i++) begin
      if (out_valid && valid_at < 0) begin
        valid_at = i;
        check("even_out_a", 32'(out_a), 32'h12);
        check("even_out_b", 32'(out_b), 32'h34);
      end
      busy_cycles++;
      tick;
    end
    check("even_latency", 32'(valid_at),    32'd4);
    check("even_busy",    32'(busy_cycles), 32'd5);

    // Zero count with backpressure; a pending pair must wait for IDLE.
    in_a = 8'h01; in_b = 8'h02; in_swaps = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_a = 8'hFF; in_b = 8'hEE; in_swaps = 4'd2;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_out_a",    32'(out_a),     32'h01);
      check("bp_out_b",    32'(out_b),     32'h02);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      tick;
    end
    check("bp_valid_4th", 32'(out_valid), 32'd1);
    check("bp_out_a_4th", 32'(out_a),     32'h01);
    out_ready = 1'b1;
    tick;
    check("bp_released_valid", 32'(out_valid), 32'd0);
    check("bp_released_ready", 32'(in_ready),  32'd1);
    tick;
    in_valid = 1'b0;
    check("held_accept_busy", 32'(busy), 32'd1);
    tick;
    tick;
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_out_a", 32'(out_a),     32'hFF);
    check("held_out_b", 32'(out_b),     32'hEE);
    tick;
    check("held_idle",  32'(in_ready),  32'd1);

    // Reset during SWAP discards the transaction.
    in_a = 8'h11; in_b = 8'h22; in_swaps = 4'd15; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    check("mid_busy_pre", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    #1 reset_n = 1'b1;
    tick;
    run_txn(8'h55, 8'hAA, 4'd3, ga, gb, lat);
    check("post_rst_out_a",   32'(ga),  32'hAA);
    check("post_rst_out_b",   32'(gb),  32'h55);
    check("post_rst_latency", 32'(lat), 32'd3);

`ifdef PAIR_EXCHANGE_STATS_EN
    #1 reset_n = 1'b0;
    #1 check("stats_reset", 32'(swap_total), 32'd0);
    #1 reset_n = 1'b1;
    tick;
    run_txn(8'h01, 8'h02, 4'd3, ga, gb, lat);
    run_txn(8'h03, 8'h04, 4'd0, ga, gb, lat);
    run_txn(8'h05, 8'h06, 4'd5, ga, gb, lat);
    check("stats_total", 32'(swap_total), 32'd8);
    force dut.swap_total_q = 16'hFFFE;
    #1 release dut.swap_total_q;
    run_txn(8'h07, 8'h08, 4'd3, ga, gb, lat);
    check("stats_saturate", 32'(swap_total), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
